mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter between the pipeline's instruction-fetch and data-memory requesters and the shared RAM. It serializes requests, gives data accesses strict priority, and returns one-cycle `ihit`/`dhit` completion pulses. The pipeline hazard logic consumes these pulses to release fetch and memory-stage stalls. A watchdog aborts any RAM access that never completes.

## Interface
- `DATA_W`, 32: data and address width.
- `TIMEOUT`, 64: maximum number of access-state cycles to wait for `ramready`. Legal range is 2..1024.
- `CLK`  in  1  clock; all logic is on the rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `iREN`  in  1  instruction read request; level, held until `ihit`.
- `iaddr`  in  DATA_W  instruction address.
- `iload`  out  DATA_W  instruction word; valid while `ihit` is high and held afterward.
- `ihit`  out  1  instruction access complete; one-cycle pulse.
- `dREN`, `dWEN`  in  1  data read / write request; level, held until `dhit`.
- `daddr`, `dstore`  in  DATA_W  data address and write data.
- `dload`  out  DATA_W  read data; valid while `dhit` is high for a read, and held afterward.
- `dhit`  out  1  data access complete; one-cycle pulse.
- `ramREN`, `ramWEN`  out  1  RAM read / write enables.
- `ramaddr`, `ramstore`  out  DATA_W  RAM address and write data.
- `ramload`  in  DATA_W  RAM read data; sampled only when `ramready` is high.
- `ramready`  in  1  RAM access complete; one-cycle pulse.
- `err`  out  1  watchdog abort; one-cycle pulse.

## Operation
- The FSM has four states: IDLE, DATA, INSTR, DONE.
- **IDLE.**
  - If `dREN|dWEN` is high: latch `daddr`, `dstore` and the op, then go to DATA. Write wins if both `dREN` and `dWEN` are high.
  - Else if `iREN` is high: latch `iaddr`, then go to INSTR.
  - Data has strict priority. When both requesters are pending, the instruction request waits.
- **DATA / INSTR.**
  - RAM outputs are driven only from the latched registers, never from live requester inputs.
  - `ramREN` is high for a read or fetch; `ramWEN` is high for a write. The two are never high together.
  - On `ramready`: capture `ramload` into `iload` (INSTR) or into `dload` (data read only). A data write leaves `dload` unchanged. Then go to DONE.
- **DONE.**
  - Assert `ihit` or `dhit` according to the completed access. Go to IDLE.
  - No new request is accepted in this cycle. This lets the requester drop or change its request on the hit edge without a duplicate access.
- **Watchdog.**
  - A counter (ceil(log2(TIMEOUT+1)) bits) clears on entry to DATA or INSTR.
  - It increments on each access cycle in which `ramready` is low.
  - When it reaches TIMEOUT, go to IDLE and pulse `err` the next cycle. No hit is issued and the load registers are unchanged.
- **Requester drops its request mid-access.** The access completes anyway, because a RAM write cannot be revoked, and the hit still pulses.
- `ramready` is ignored in IDLE and DONE.
- **Reset.** Applies regardless of state, including mid-access. State goes to IDLE and all outputs go to 0 the following cycle; the RAM transaction is abandoned.

## Timing
- Reset values: `ihit`=0, `dhit`=0, `err`=0, `iload`=0, `dload`=0, `ramREN`=0, `ramWEN`=0, `ramaddr`=0, `ramstore`=0.
- A request sampled at edge k puts the RAM enables high in cycle k+1.
- `ramready` high in cycle m puts the hit high in cycle m+1. Minimum request-to-hit latency is 2 cycles, when `ramready` is high in the first access cycle.
- The earliest next acceptance is the IDLE cycle m+2, so the earliest next RAM enable is cycle m+3.
- `ramready` and the watchdog limit in the same cycle: `ramready` wins, a normal hit is issued, and there is no `err`.
- The watchdog fires in the cycle after the TIMEOUT-th consecutive access cycle without `ramready`.
- `ihit` and `dhit` are never high in the same cycle. `err` and any hit are never high in the same cycle.
- All outputs are registered or decoded directly from state and latched registers. There is no combinational path from requester inputs to RAM outputs.

## Test plan
- **Reset:** `RST`=1 for 2 cycles with `iREN`=1 → all outputs 0. After release, `ramREN`=1 with `ramaddr`=`iaddr` on the first cycle after sampling.
- **Fetch:** `iREN`=1, `iaddr`=0x40, RAM returns 0x2108000A after 3 cycles → `ihit` is a single pulse one cycle after `ramready`, `iload`=0x2108000A, and no second access starts while `iREN` is held through the hit edge.
- **Priority:** `iREN`=1 and `dWEN`=1 with `daddr`=0x80, `dstore`=0xDEADBEEF in the same cycle → the RAM write to 0x80 completes first with `dhit`, then the fetch is issued. `dload` is unchanged.
- **Requester drop:** data read of 0x100 is accepted, then `dREN` drops mid-access → RAM read still completes, `dhit` pulses, `dload`=`ramload`.
- **Watchdog:** TIMEOUT=4 with `ramready` never asserted → `err` pulses in the cycle after the 4th access cycle, returns to IDLE, no hit. Repeat with `ramready` on cycle 4 → `dhit`, no `err`.
- **Reset mid-access:** `RST` in the 2nd cycle of a write → `ramWEN`=0 the next cycle, no hit, and the next request is served normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and RAM bundle for the single-port memory arbiter.
// slave: arbiter view; master: requester/RAM environment view.
interface mem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [DATA_W-1:0] iaddr;
    logic [DATA_W-1:0] iload;
    logic              ihit;
    logic              dREN;
    logic              dWEN;
    logic [DATA_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [DATA_W-1:0] dload;
    logic              dhit;
    logic              ramREN;
    logic              ramWEN;
    logic [DATA_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;
    logic              err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramready,
        output iload, ihit, dload, dhit,
        output ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramready,
        input  iload, ihit, dload, dhit,
        input  ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data-priority serialisation of fetch and
// data requests with one-cycle hit pulses and an access watchdog.
// Ports: CLK, RST (sync, active-high), bus (mem_arbiter_if.slave).
module mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic [DATA_W-1:0] iload_q;
    logic [DATA_W-1:0] dload_q;
    logic              wen_q;
    logic              sel_d_q;
    logic              err_q;
    logic [CW-1:0]     wd_cnt;
    logic              access;
    logic              wd_expire;

    assign access    = (state_q == DATA) || (state_q == INSTR);
    // Last allowed miss: this cycle is the TIMEOUT-th without ramready.
    assign wd_expire = access && !bus.ramready
                       && (wd_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.dREN || bus.dWEN)
                    state_d = DATA;
                else if (bus.iREN)
                    state_d = INSTR;
            end
            DATA, INSTR: begin
                // ramready beats the watchdog in the same cycle.
                if (bus.ramready)
                    state_d = DONE;
                else if (wd_expire)
                    state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
            wen_q   <= 1'b0;
            sel_d_q <= 1'b0;
            err_q   <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= wd_expire;
            if (state_q == IDLE) begin
                if (bus.dREN || bus.dWEN) begin
                    addr_q  <= bus.daddr;
                    store_q <= bus.dstore;
                    wen_q   <= bus.dWEN;
                    sel_d_q <= 1'b1;
                    wd_cnt  <= '0;
                end else if (bus.iREN) begin
                    addr_q  <= bus.iaddr;
                    wen_q   <= 1'b0;
                    sel_d_q <= 1'b0;
                    wd_cnt  <= '0;
                end
            end
            if (access) begin
                if (bus.ramready) begin
                    if (state_q == INSTR)
                        iload_q <= bus.ramload;
                    else if (!wen_q)
                        dload_q <= bus.ramload;
                end else begin
                    wd_cnt <= wd_cnt + CW'(1);
                end
            end
        end
    end

    // RAM side is decoded from state and latched request only.
    assign bus.ramREN   = (state_q == INSTR)
                          || ((state_q == DATA) && !wen_q);
    assign bus.ramWEN   = (state_q == DATA) && wen_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.iload    = iload_q;
    assign bus.dload    = dload_q;
    assign bus.ihit     = (state_q == DONE) && !sel_d_q;
    assign bus.dhit     = (state_q == DONE) && sel_d_q;
    assign bus.err      = err_q;
endmodule
